axi_ctrl_writer: RTL and testbench
==================================

# axi_ctrl_writer

Single-beat AXI3 write initiator that drives 32-bit register writes into memory-mapped control slaves such as the computer control register block (mem_start at BASE_ADDR, interrupt ack at BASE_ADDR+4). It accepts one command at a time from a local valid/ready port and issues AW and W together. It then waits for the B response with ID checking and a response timeout, and reports completion with a one-cycle done pulse. It sits between host-side sequencing logic and the AXI interconnect.

## Interface
- ID_BASE, 12'h000: upper 8 bits form awid/wid[11:4]; the low 4 bits are the transaction sequence number.
- TIMEOUT, 1024: maximum cycles spent in RESP before abort. 0 disables the timeout.
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  32  target byte address.
- cmd_data  in  32  write data.
- done  out  1  one-cycle completion pulse.
- resp  out  2  bresp of the completed transaction, or 2'b10 on timeout; held until the next done.
- timeout  out  1  set with done when the transaction timed out; held until the next done.
- awid/wid  out  12  {ID_BASE[11:4], seq}.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- awaddr  out  32  latched cmd_addr.
- awlen  out  8  constant 0.
- awsize  out  3  constant 3'b010.
- awburst  out  2  constant 2'b01.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- wdata  out  32  latched cmd_data.
- wstrb  out  4  constant 4'hF.
- wlast  out  1  constant 1.
- bid  in  12  response ID.
- bresp  in  2  response code.
- bvalid  in  1  response valid.
- bready  out  1  high only in RESP.

## Operation
- States: IDLE, ADDR_DATA, RESP.
- IDLE:
  - A handshake on cmd_valid && cmd_ready latches cmd_addr into awaddr and cmd_data into wdata.
  - It sets awvalid=1 and wvalid=1 and moves to ADDR_DATA.
- ADDR_DATA:
  - awvalid clears on the awvalid && awready handshake.
  - wvalid clears on the wvalid && wready handshake.
  - The two handshakes happen in either order or in the same cycle.
  - A valid is never withdrawn before its handshake.
  - When both handshakes are complete (registered flags, or both in the same cycle), the block moves to RESP, sets bready=1 and clears the timeout counter.
- RESP:
  - Matching response (bvalid && bid==awid): capture bresp into resp, set timeout=0, pulse done, increment seq, go to IDLE and clear bready.
  - Stale response (bvalid && bid!=awid): accept and discard it. The block stays in RESP and the counter keeps running.
  - Counter reaches TIMEOUT-1 with no matching response that cycle: set resp=2'b10, timeout=1, pulse done, increment seq, go to IDLE.
  - A matching response in the final cycle takes priority over the timeout.
- seq is 4 bits and wraps from 15 to 0. Incrementing on a timeout lets a late response to the abandoned transaction be discarded as stale later on.
- The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates. It is frozen when TIMEOUT==0.
- Reset asserted mid-transaction: all valids drop immediately and the block returns to IDLE. No done is generated.

## Timing
- Reset values:
  - cmd_ready=1, done=0, resp=0, timeout=0.
  - awvalid=0, wvalid=0, bready=0.
  - awaddr=0, wdata=0, seq=0.
- awvalid, wvalid, bready, done, resp and timeout are registered. cmd_ready is decoded from the state register.
- Command accepted at edge N: awvalid and wvalid are high from cycle N+1.
- Slave with awready=wready=1 and bvalid on the first RESP cycle:
  - RESP is entered at N+2 and the response handshake occurs at N+2.
  - done is high in N+3 and cmd_ready is high again in N+3.
  - Minimum throughput is one write per 3 cycles.
- bready falls in the same edge that raises done.
- Stale responses consume one cycle each.

## Test plan
- Zero-wait write: cmd addr 0x4000_0000, data 0x1234_5678, slave always ready, bresp=0.
  - Expect one AW and one W beat with awlen=0, awsize=2, wstrb=F, wlast=1.
  - Expect done at N+3 with resp=0 and timeout=0.
- Skewed handshakes: wready delayed 5 cycles after awready, then the reverse.
  - awvalid drops after its own handshake.
  - wvalid stays high until wready.
  - Exactly one beat per channel.
- Error response: the slave returns bresp=2 for an address of 0x4000_0008.
  - done pulses with resp=2 and timeout=0.
- Stale response: in RESP, drive bvalid with bid={ID_BASE[11:4],seq-1}, then the matching bid with bresp=0.
  - The stale response is absorbed.
  - done follows the matching response only, with resp=0.
- Timeout with TIMEOUT=8: bvalid never asserted.
  - done at the 8th RESP cycle with resp=2 and timeout=1, then seq+1.
  - A matching response on exactly the 8th cycle yields timeout=0 instead.
- Async reset: pulse rstn low while awvalid is high and awready is low.
  - awvalid drops without waiting for a clock edge.
  - All outputs take their reset values.
  - No done pulse.
  - A new command completes normally with awid low bits = 0.

Source files
------------

// File: rtl/axi_ctrl_writer_if.sv
// AXI3 write-channel bundle between the control writer and the interconnect.
// Covers AW, W and B channels for single-beat 32-bit register writes.
interface axi_ctrl_writer_if;
    logic [11:0] awid;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [11:0] wid;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awvalid, awaddr, awlen, awsize, awburst,
        output wid, wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awvalid, awaddr, awlen, awsize, awburst,
        input  wid, wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_ctrl_writer.sv
// Single-beat AXI3 write initiator for 32-bit control registers.
// AW and W issued together; B checked by ID with an optional timeout.
module axi_ctrl_writer #(
    parameter logic [11:0] ID_BASE = 12'h000,
    parameter int          TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        done,
    output logic [1:0]  resp,
    output logic        timeout,
    axi_ctrl_writer_if.master axi
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    seq;
    logic [CW-1:0] cnt;
    logic          aw_done;
    logic          w_done;
    logic [11:0]   id;
    logic          aw_hs;
    logic          w_hs;
    logic          b_match;
    logic          expire;

    assign id          = {ID_BASE[11:4], seq};
    assign axi.awid    = id;
    assign axi.wid     = id;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.wstrb   = 4'hF;
    assign axi.wlast   = 1'b1;
    assign cmd_ready   = (state == IDLE);

    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign b_match = axi.bvalid && (axi.bid == id);
    assign expire  = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Transaction FSM: command latch, AW/W handshakes, B wait with timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            seq         <= 4'd0;
            cnt         <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            axi.awaddr  <= 32'd0;
            axi.wdata   <= 32'd0;
            done        <= 1'b0;
            resp        <= 2'b00;
            timeout     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        axi.awaddr  <= cmd_addr;
                        axi.wdata   <= cmd_data;
                        axi.awvalid <= 1'b1;
                        axi.wvalid  <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        state       <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (aw_hs) begin
                        axi.awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        axi.wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state      <= RESP;
                        axi.bready <= 1'b1;
                        cnt        <= '0;
                    end
                end
                RESP: begin
                    if ((TIMEOUT != 0) && (cnt != CNT_MAX)) begin
                        cnt <= cnt + CW'(1);
                    end
                    // A matching response wins over a same-cycle expiry.
                    if (b_match || expire) begin
                        resp       <= b_match ? axi.bresp : 2'b10;
                        timeout    <= !b_match;
                        done       <= 1'b1;
                        seq        <= seq + 4'd1;
                        axi.bready <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ctrl_writer.sv
// Directed bench for axi_ctrl_writer with a response scoreboard.
// Expected done/resp/timeout/seq are queued at command issue.
module tb_axi_ctrl_writer;

    localparam logic [11:0] IDB = 12'hA50;
    localparam int          TO  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        done;
    logic [1:0]  resp;
    logic        timeout;

    axi_ctrl_writer_if bus();

    axi_ctrl_writer #(
        .ID_BASE (IDB),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .done      (done),
        .resp      (resp),
        .timeout   (timeout),
        .axi       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] resp;
        logic       to;
        logic [3:0] seq;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         aw_cnt = 0;
    int         w_cnt = 0;
    int         b_cnt = 0;
    logic [3:0] exp_seq = 4'd0;

    // Beat monitor: counts completed handshakes on each channel.
    always @(posedge clk) begin
        if (rstn) begin
            if (bus.awvalid && bus.awready) aw_cnt++;
            if (bus.wvalid && bus.wready) w_cnt++;
            if (bus.bvalid && bus.bready) b_cnt++;
        end
    end

    function automatic logic [11:0] cur_id();
        return {IDB[11:4], exp_seq};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] er, input logic eto);
        exp_t e;
        e.resp = er;
        e.to   = eto;
        e.seq  = exp_seq;
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        chk("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("awvalid_set", bus.awvalid, 1);
        chk("wvalid_set", bus.wvalid, 1);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("awaddr", bus.awaddr, a);
        chk("wdata", bus.wdata, d);
        chk("awid", bus.awid, cur_id());
        chk("wid", bus.wid, cur_id());
    endtask

    task automatic wait_done(input int max, output int n);
        exp_t       e;
        logic [11:0] nid;
        n = -1;
        for (int i = 0; i < max; i++) begin
            step();
            if (done) begin
                n = i + 1;
                break;
            end
        end
        if (n < 0) begin
            chk("done_seen", done, 1);
        end else if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            nid = {IDB[11:4], e.seq + 4'd1};
            chk("resp", resp, e.resp);
            chk("timeout", timeout, e.to);
            chk("bready_drop", bus.bready, 0);
            chk("cmd_ready_back", cmd_ready, 1);
            chk("awid_next", bus.awid, nid);
            exp_seq = e.seq + 4'd1;
            step();
            chk("done_pulse", done, 0);
            chk("resp_hold", resp, e.resp);
            chk("timeout_hold", timeout, e.to);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int aw0;
        int w0;
        int b0;
        logic [11:0] stale;

        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bid     = 12'd0;
        bus.bresp   = 2'b00;

        // Reset state
        #3;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_resp", resp, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_awid", bus.awid, {IDB[11:4], 4'd0});
        step();
        step();
        rstn = 1'b1;
        step();

        // Zero-wait write
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        aw0 = aw_cnt;
        w0  = w_cnt;
        b0  = b_cnt;
        issue(32'h4000_0000, 32'h1234_5678, 2'b00, 1'b0);
        chk("awlen", bus.awlen, 0);
        chk("awsize", bus.awsize, 3'b010);
        chk("awburst", bus.awburst, 2'b01);
        chk("wstrb", bus.wstrb, 4'hF);
        chk("wlast", bus.wlast, 1);
        step();
        chk("zw_bready", bus.bready, 1);
        chk("zw_awvalid_low", bus.awvalid, 0);
        chk("zw_wvalid_low", bus.wvalid, 0);
        bus.bvalid = 1'b1;
        bus.bid    = cur_id();
        bus.bresp  = 2'b00;
        wait_done(4, n);
        bus.bvalid = 1'b0;
        chk("zw_latency", n, 1);
        chk("zw_aw_beats", aw_cnt - aw0, 1);
        chk("zw_w_beats", w_cnt - w0, 1);
        chk("zw_b_beats", b_cnt - b0, 1);

        // AW first, W five cycles later
        bus.awready = 1'b1;
        bus.wready  = 1'b0;
        aw0 = aw_cnt;
        w0  = w_cnt;
        issue(32'h4000_0004, 32'h0000_0001, 2'b00, 1'b0);
        step();
        chk("skA_awvalid_low", bus.awvalid, 0);
        chk("skA_wvalid_high", bus.wvalid, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("skA_wvalid_hold", bus.wvalid, 1);
            chk("skA_no_bready", bus.bready, 0);
        end
        bus.wready = 1'b1;
        step();
        chk("skA_wvalid_low", bus.wvalid, 0);
        chk("skA_bready", bus.bready, 1);
        bus.bvalid = 1'b1;
        bus.bid    = cur_id();
        bus.bresp  = 2'b00;
        wait_done(4, n);
        bus.bvalid = 1'b0;
        chk("skA_aw_beats", aw_cnt - aw0, 1);
        chk("skA_w_beats", w_cnt - w0, 1);

        // W first, AW five cycles later
        bus.awready = 1'b0;
        bus.wready  = 1'b1;
        aw0 = aw_cnt;
        w0  = w_cnt;
        issue(32'h4000_0004, 32'h0000_0002, 2'b00, 1'b0);
        step();
        chk("skB_wvalid_low", bus.wvalid, 0);
        chk("skB_awvalid_high", bus.awvalid, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("skB_awvalid_hold", bus.awvalid, 1);
        end
        bus.awready = 1'b1;
        step();
        chk("skB_awvalid_low", bus.awvalid, 0);
        chk("skB_bready", bus.bready, 1);
        bus.bvalid = 1'b1;
        bus.bid    = cur_id();
        bus.bresp  = 2'b00;
        wait_done(4, n);
        bus.bvalid = 1'b0;
        chk("skB_aw_beats", aw_cnt - aw0, 1);
        chk("skB_w_beats", w_cnt - w0, 1);

        // Error response
        bus.wready = 1'b1;
        issue(32'h4000_0008, 32'hDEAD_BEEF, 2'b10, 1'b0);
        step();
        bus.bvalid = 1'b1;
        bus.bid    = cur_id();
        bus.bresp  = 2'b10;
        wait_done(4, n);
        bus.bvalid = 1'b0;
        chk("err_latency", n, 1);

        // Stale response absorbed, then matching one
        issue(32'h4000_0000, 32'h0000_00AA, 2'b00, 1'b0);
        step();
        stale      = {IDB[11:4], exp_seq - 4'd1};
        b0         = b_cnt;
        bus.bvalid = 1'b1;
        bus.bid    = stale;
        bus.bresp  = 2'b11;
        step();
        chk("stale_no_done", done, 0);
        chk("stale_bready", bus.bready, 1);
        chk("stale_accepted", b_cnt - b0, 1);
        bus.bid   = cur_id();
        bus.bresp = 2'b00;
        wait_done(4, n);
        bus.bvalid = 1'b0;
        chk("stale_latency", n, 1);

        // Timeout with no response
        issue(32'h4000_0004, 32'h0000_0003, 2'b10, 1'b1);
        step();
        wait_done(20, n);
        chk("to_latency", n, TO);

        // Matching response in the final cycle beats the timeout
        issue(32'h4000_0004, 32'h0000_0004, 2'b01, 1'b0);
        step();
        for (int i = 0; i < TO - 1; i++) begin
            step();
            chk("to_last_wait", done, 0);
        end
        bus.bvalid = 1'b1;
        bus.bid    = cur_id();
        bus.bresp  = 2'b01;
        wait_done(2, n);
        bus.bvalid = 1'b0;
        chk("to_last_latency", n, 1);

        // Async reset mid-transaction
        bus.awready = 1'b0;
        issue(32'h4000_0000, 32'h5555_5555, 2'b00, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_awvalid", bus.awvalid, 0);
        chk("ar_wvalid", bus.wvalid, 0);
        chk("ar_cmd_ready", cmd_ready, 1);
        chk("ar_awaddr", bus.awaddr, 0);
        chk("ar_wdata", bus.wdata, 0);
        chk("ar_resp", resp, 0);
        chk("ar_timeout", timeout, 0);
        chk("ar_awid", bus.awid, {IDB[11:4], 4'd0});
        sb.delete();
        step();
        chk("ar_no_done0", done, 0);
        step();
        chk("ar_no_done1", done, 0);
        rstn    = 1'b1;
        exp_seq = 4'd0;
        step();
        chk("ar_no_done2", done, 0);
        bus.awready = 1'b1;
        issue(32'h4000_0004, 32'h0000_0001, 2'b00, 1'b0);
        step();
        bus.bvalid = 1'b1;
        bus.bid    = cur_id();
        bus.bresp  = 2'b00;
        wait_done(4, n);
        bus.bvalid = 1'b0;
        chk("ar_new_latency", n, 1);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
